filter_config_ctrl: RTL and testbench
=====================================

// Module: filter_config_ctrl
// PURPOSE
//  Configures the active filter selected by filter_fsm. Two held (debounced-level) adjust buttons step a
//  per-filter parameter up/down, with auto-repeat while held. Edits go to shadow registers. Shadow values
//  commit to the datapath-facing outputs only at frame_start, so a frame never sees a mid-frame change.
// PARAMETERS
//  LEVEL_BITS     4     width of every parameter output
//  BLUR_MAX       3     max blur_level; saturates at 0..BLUR_MAX
//  BRIGHT_DEFAULT 8     reset value of brightness
//  EDGE_DEFAULT   6     reset value of edge_thresh
//  REPEAT_DELAY   2500  cycles from a press to the first auto-repeat step
//  REPEAT_PERIOD  500   cycles between later auto-repeat steps
// PORTS
//  clk          in   1           system clock
//  reset        in   1           synchronous, active-high reset
//  filter_type  in   2           00 COLOUR, 01 BLUR, 10 BRIGHTNESS, 11 EDGES (from filter_fsm)
//  inc_held     in   1           debounced level, 1 = increment button held
//  dec_held     in   1           debounced level, 1 = decrement button held
//  frame_start  in   1           single-cycle pulse at frame boundary (vsync)
//  colour_sel   out  2           active colour channel select
//  blur_level   out  LEVEL_BITS  active blur strength
//  brightness   out  LEVEL_BITS  active brightness level
//  edge_thresh  out  LEVEL_BITS  active edge threshold
//  cfg_pending  out  1           shadow differs from active (edit awaiting frame_start)
//  cfg_update   out  1           one-cycle pulse, the cycle after a commit that changed a value
// BEHAVIOUR
//  Reset values:
//   - colour_sel=0, blur_level=0, brightness=BRIGHT_DEFAULT, edge_thresh=EDGE_DEFAULT.
//   - Shadow registers take the same values. cfg_pending=0, cfg_update=0, FSM=IDLE.
//  Direction: dir = inc_held ^ dec_held. Both held or neither held counts as no press.
//  Repeat FSM (IDLE, DELAY, REPEAT), one down-counter:
//   - IDLE -> DELAY on the rising edge of exactly one held input (edge vs registered copy).
//     Emit one step that cycle. Load counter with REPEAT_DELAY-1.
//   - DELAY: when counter==0, emit a step, load REPEAT_PERIOD-1, go to REPEAT.
//   - REPEAT: when counter==0, emit a step and reload REPEAT_PERIOD-1.
//   - DELAY/REPEAT -> IDLE with no step in these cases:
//     (a) the held button is released;
//     (b) both buttons become held;
//     (c) filter_type changes.
//     After (b) or (c), a new step needs a fresh rising edge.
//  Step target is chosen by the current filter_type; it updates the shadow on the next clk edge.
//   - COLOUR: colour_sel +1/-1 mod 4 (3+1 wraps to 0, 0-1 wraps to 3).
//   - BLUR: saturate at 0..BLUR_MAX.
//   - BRIGHTNESS, EDGES: saturate at 0..2^LEVEL_BITS-1.
//   - A saturated step leaves the shadow unchanged and raises no cfg_pending.
//  Commit: on frame_start, active <= shadow (all four registers) at the same edge.
//   - A step in the same cycle as frame_start lands in the shadow only.
//     Active takes the pre-step shadow; the step commits at the next frame_start.
//   - cfg_update pulses the cycle after a commit in which any active value changed.
//   - cfg_pending = (shadow != active), registered. It clears the cycle after commit.
//  Reset mid-hold: FSM to IDLE. A button still held after reset deasserts gives no step until re-pressed.
//  Outputs hold between commits regardless of inputs.
// STRUCTURE
//  - Package filter_pkg: filter_type_t enum (COLOUR=2'b00, BLUR=2'b01, BRIGHTNESS=2'b10,
//    EDGES=2'b11) and repeat_state_t. Shared with filter_fsm.
//  - Sub-module key_autorepeat: edge detect, IDLE/DELAY/REPEAT FSM and counter.
//    Ports: clk, reset, inc_held, dec_held, cancel.
//    Outputs: step_up / step_dn pulses.
//  - Top level holds the shadow/active registers, saturation/wrap logic and commit logic.
// TESTING (REPEAT_DELAY=4, REPEAT_PERIOD=2, LEVEL_BITS=4, BLUR_MAX=3)
//  1. Reset, then frame_start -> outputs 0/0/8/6, cfg_update stays 0, cfg_pending 0.
//  2. BRIGHTNESS, inc_held high for 10 cycles -> 4 steps (cycles 0,4,6,8); shadow 12, cfg_pending=1.
//     Then frame_start -> brightness=12 and cfg_update pulse.
//  3. BLUR, inc_held high 20 cycles -> shadow saturates at 3. dec from 0 stays 0.
//     COLOUR at 3 with inc tapped -> 0 after commit.
//  4. inc_held and dec_held rise together -> no step, FSM IDLE. Release dec -> still no step (no fresh edge).
//  5. filter_type switches BRIGHTNESS->EDGES mid-hold -> repeat stops, edge_thresh unchanged until re-press.
//  6. Step in the same cycle as frame_start -> active keeps old value, cfg_pending=1.
//     It commits on the next frame_start. Reset asserted mid-REPEAT -> all reset values next cycle.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared types for the filter selection FSM and the filter configuration controller.
package filter_pkg;

  typedef enum logic [1:0] {
    COLOUR     = 2'b00,
    BLUR       = 2'b01,
    BRIGHTNESS = 2'b10,
    EDGES      = 2'b11
  } filter_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DELAY  = 2'b01,
    REPEAT = 2'b10
  } repeat_state_t;

endpackage

// File: rtl/filter_config_if.sv
// Button/frame inputs and committed filter parameters of the configuration controller.
interface filter_config_if
  import filter_pkg::*;
#(
  parameter int LEVEL_BITS = 4
);
  filter_type_t          filter_type;
  logic                  inc_held;
  logic                  dec_held;
  logic                  frame_start;
  logic [1:0]            colour_sel;
  logic [LEVEL_BITS-1:0] blur_level;
  logic [LEVEL_BITS-1:0] brightness;
  logic [LEVEL_BITS-1:0] edge_thresh;
  logic                  cfg_pending;
  logic                  cfg_update;
  repeat_state_t         rpt_state;

  // No valid/ready handshake: inputs are levels or pulses sampled every clk,
  // outputs are registered and only change on a commit or reset.
  modport master (
    output filter_type, inc_held, dec_held, frame_start,
    input  colour_sel, blur_level, brightness, edge_thresh,
    input  cfg_pending, cfg_update, rpt_state
  );

  modport slave (
    input  filter_type, inc_held, dec_held, frame_start,
    output colour_sel, blur_level, brightness, edge_thresh,
    output cfg_pending, cfg_update, rpt_state
  );
endinterface

// File: rtl/key_autorepeat.sv
// Press edge detect and IDLE/DELAY/REPEAT auto-repeat for an inc/dec button pair.
module key_autorepeat
  import filter_pkg::*;
#(
  parameter int REPEAT_DELAY  = 2500,
  parameter int REPEAT_PERIOD = 500
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc_held,
  input  logic          dec_held,
  input  logic          cancel,
  output logic          step_up,
  output logic          step_dn,
  output repeat_state_t state
);
  localparam int MAX_LOAD = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W    = (MAX_LOAD > 2) ? $clog2(MAX_LOAD) : 1;
  localparam logic [CNT_W-1:0] LOAD_DELAY  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] LOAD_PERIOD = CNT_W'(REPEAT_PERIOD - 1);

  repeat_state_t    state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir_up, dir_nxt;
  logic             inc_q, dec_q;
  logic             step, press, still_held;

  // Edge history tracks the buttons even during reset, so a button held
  // through reset never looks like a fresh press afterwards.
  always_ff @(posedge clk) begin
    inc_q <= inc_held;
    dec_q <= dec_held;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      dir_up <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dir_up <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dir_nxt    = dir_up;
    step       = 1'b0;
    press      = (inc_held ^ dec_held) &
                 ((inc_held & ~inc_q) | (dec_held & ~dec_q));
    still_held = dir_up ? (inc_held & ~dec_held) : (dec_held & ~inc_held);
    case (state)
      IDLE: begin
        if (press) begin
          state_nxt = DELAY;
          cnt_nxt   = LOAD_DELAY;
          dir_nxt   = inc_held;
          step      = 1'b1;
        end
      end
      DELAY, REPEAT: begin
        if (cancel || !still_held) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = REPEAT;
          cnt_nxt   = LOAD_PERIOD;
          step      = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    step_up = step & dir_nxt;
    step_dn = step & ~dir_nxt;
  end

endmodule

// File: rtl/filter_config_ctrl.sv
// Shadow/active filter parameters: button steps edit the shadow, frame_start commits it.
module filter_config_ctrl
  import filter_pkg::*;
#(
  parameter int LEVEL_BITS     = 4,
  parameter int BLUR_MAX       = 3,
  parameter int BRIGHT_DEFAULT = 8,
  parameter int EDGE_DEFAULT   = 6,
  parameter int REPEAT_DELAY   = 2500,
  parameter int REPEAT_PERIOD  = 500
) (
  input logic             clk,
  input logic             reset,
  filter_config_if.slave  cfg
);
  localparam logic [LEVEL_BITS-1:0] BLUR_TOP = LEVEL_BITS'(BLUR_MAX);
  localparam logic [LEVEL_BITS-1:0] LVL_TOP  = '1;

  logic                  step_up, step_dn, cancel;
  filter_type_t          ft_q;
  logic [1:0]            sh_col, sh_col_nxt, act_col, act_col_nxt;
  logic [LEVEL_BITS-1:0] sh_blur, sh_blur_nxt, act_blur, act_blur_nxt;
  logic [LEVEL_BITS-1:0] sh_bri, sh_bri_nxt, act_bri, act_bri_nxt;
  logic [LEVEL_BITS-1:0] sh_edge, sh_edge_nxt, act_edge, act_edge_nxt;
  logic                  pending, update;

  // A repeat run belongs to one filter; switching filters ends it.
  always_ff @(posedge clk) ft_q <= cfg.filter_type;
  assign cancel = (cfg.filter_type != ft_q);

  key_autorepeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_repeat (
    .clk      (clk),
    .reset    (reset),
    .inc_held (cfg.inc_held),
    .dec_held (cfg.dec_held),
    .cancel   (cancel),
    .step_up  (step_up),
    .step_dn  (step_dn),
    .state    (cfg.rpt_state)
  );

  always_comb begin
    sh_col_nxt  = sh_col;
    sh_blur_nxt = sh_blur;
    sh_bri_nxt  = sh_bri;
    sh_edge_nxt = sh_edge;
    case (cfg.filter_type)
      COLOUR: begin
        if (step_up)      sh_col_nxt = sh_col + 2'd1;
        else if (step_dn) sh_col_nxt = sh_col - 2'd1;
      end
      BLUR: begin
        if (step_up && sh_blur < BLUR_TOP)     sh_blur_nxt = sh_blur + 1'b1;
        else if (step_dn && sh_blur != '0)     sh_blur_nxt = sh_blur - 1'b1;
      end
      BRIGHTNESS: begin
        if (step_up && sh_bri != LVL_TOP)      sh_bri_nxt = sh_bri + 1'b1;
        else if (step_dn && sh_bri != '0)      sh_bri_nxt = sh_bri - 1'b1;
      end
      EDGES: begin
        if (step_up && sh_edge != LVL_TOP)     sh_edge_nxt = sh_edge + 1'b1;
        else if (step_dn && sh_edge != '0)     sh_edge_nxt = sh_edge - 1'b1;
      end
      default: ;
    endcase
    // Commit takes the pre-step shadow; a step in the commit cycle waits a frame.
    act_col_nxt  = cfg.frame_start ? sh_col  : act_col;
    act_blur_nxt = cfg.frame_start ? sh_blur : act_blur;
    act_bri_nxt  = cfg.frame_start ? sh_bri  : act_bri;
    act_edge_nxt = cfg.frame_start ? sh_edge : act_edge;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_col   <= '0;
      sh_blur  <= '0;
      sh_bri   <= LEVEL_BITS'(BRIGHT_DEFAULT);
      sh_edge  <= LEVEL_BITS'(EDGE_DEFAULT);
      act_col  <= '0;
      act_blur <= '0;
      act_bri  <= LEVEL_BITS'(BRIGHT_DEFAULT);
      act_edge <= LEVEL_BITS'(EDGE_DEFAULT);
      pending  <= 1'b0;
      update   <= 1'b0;
    end else begin
      sh_col   <= sh_col_nxt;
      sh_blur  <= sh_blur_nxt;
      sh_bri   <= sh_bri_nxt;
      sh_edge  <= sh_edge_nxt;
      act_col  <= act_col_nxt;
      act_blur <= act_blur_nxt;
      act_bri  <= act_bri_nxt;
      act_edge <= act_edge_nxt;
      update   <= cfg.frame_start &&
                  ({sh_col, sh_blur, sh_bri, sh_edge} != {act_col, act_blur, act_bri, act_edge});
      pending  <= {sh_col_nxt, sh_blur_nxt, sh_bri_nxt, sh_edge_nxt} !=
                  {act_col_nxt, act_blur_nxt, act_bri_nxt, act_edge_nxt};
    end
  end

  assign cfg.colour_sel  = act_col;
  assign cfg.blur_level  = act_blur;
  assign cfg.brightness  = act_bri;
  assign cfg.edge_thresh = act_edge;
  assign cfg.cfg_pending = pending;
  assign cfg.cfg_update  = update;

endmodule

// File: tb/tb_filter_config_ctrl.sv
// Bench for filter_config_ctrl: directed scenarios plus random button/frame traffic vs a reference model.
module tb_filter_config_ctrl;
  import filter_pkg::*;

  localparam int LB = 4, BLUR_MAX = 3, BD = 8, ED = 6, RD = 4, RP = 2;
  localparam int LMAX = (1 << LB) - 1;

  // clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  filter_config_if #(.LEVEL_BITS(LB)) cfg();

  filter_config_ctrl #(
    .LEVEL_BITS(LB), .BLUR_MAX(BLUR_MAX), .BRIGHT_DEFAULT(BD), .EDGE_DEFAULT(ED),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cfg   (cfg)
  );

  // reference model state
  int  m_col, m_blur, m_bri, m_edge;   // shadow
  int  a_col, a_blur, a_bri, a_edge;   // active
  int  m_pend;
  bit  m_pressing;
  int  m_dir, m_age;
  bit  p_inc, p_dec;
  int  p_ft;
  bit  mon_en = 1'b0;

  logic [13:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [13:0] pack_active();
    return {a_col[1:0], a_blur[3:0], a_bri[3:0], a_edge[3:0]};
  endfunction

  task automatic model_update(input int ft, input bit inc, input bit dec, input bit fs, input bit rst);
    int  step;
    bit  held_ok, changed;
    step = 0;
    if (rst) begin
      m_col = 0; m_blur = 0; m_bri = BD; m_edge = ED;
      a_col = 0; a_blur = 0; a_bri = BD; a_edge = ED;
      m_pend = 0; m_pressing = 1'b0;
    end else begin
      if (m_pressing) begin
        held_ok = (m_dir > 0) ? (inc && !dec) : (dec && !inc);
        if (ft != p_ft || !held_ok) m_pressing = 1'b0;
        else begin
          m_age++;
          if (m_age >= RD && ((m_age - RD) % RP) == 0) step = m_dir;
        end
      end else if (inc != dec) begin
        if (inc && !p_inc)      begin m_pressing = 1'b1; m_dir = 1;  m_age = 0; step = 1;  end
        else if (dec && !p_dec) begin m_pressing = 1'b1; m_dir = -1; m_age = 0; step = -1; end
      end
      if (fs) begin
        changed = (a_col != m_col) || (a_blur != m_blur) || (a_bri != m_bri) || (a_edge != m_edge);
        a_col = m_col; a_blur = m_blur; a_bri = m_bri; a_edge = m_edge;
        if (changed) exp_q.push_back(pack_active());
      end
      case (ft)
        0:       m_col  = (m_col + step + 4) % 4;
        1:       m_blur = clamp(m_blur + step, 0, BLUR_MAX);
        2:       m_bri  = clamp(m_bri + step, 0, LMAX);
        default: m_edge = clamp(m_edge + step, 0, LMAX);
      endcase
      m_pend = ((m_col != a_col) || (m_blur != a_blur) || (m_bri != a_bri) || (m_edge != a_edge)) ? 1 : 0;
    end
    p_inc = inc; p_dec = dec; p_ft = ft;
  endtask

  // driver: one clock cycle with the given inputs
  task automatic tick(input int ft, input bit inc, input bit dec, input bit fs, input bit rst);
    cfg.filter_type = filter_type_t'(ft[1:0]);
    cfg.inc_held    = inc;
    cfg.dec_held    = dec;
    cfg.frame_start = fs;
    reset           = rst;
    @(posedge clk);
    model_update(ft, inc, dec, fs, rst);
    @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (cfg.cfg_update) begin
        if (exp_q.size() == 0) check("cfg_update_unexpected", 1, 0);
        else check("commit_values",
                   int'({cfg.colour_sel, cfg.blur_level, cfg.brightness, cfg.edge_thresh}),
                   int'(exp_q.pop_front()));
      end else if (exp_q.size() != 0) begin
        check("cfg_update_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      check("active_outputs",
            int'({cfg.colour_sel, cfg.blur_level, cfg.brightness, cfg.edge_thresh}),
            int'(pack_active()));
      check("cfg_pending", int'(cfg.cfg_pending), m_pend);
      check("rpt_idle", int'(cfg.rpt_state == IDLE), int'(!m_pressing));
    end
  end

  initial begin
    int ft;
    bit inc, dec, fs, rst;
    cfg.filter_type = COLOUR; cfg.inc_held = 1'b0; cfg.dec_held = 1'b0;
    cfg.frame_start = 1'b0;  reset = 1'b1;
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    mon_en = 1'b1;

    // 1: reset values, empty commit
    check("reset_colour", int'(cfg.colour_sel), 0);
    check("reset_blur",   int'(cfg.blur_level), 0);
    check("reset_bright", int'(cfg.brightness), BD);
    check("reset_edge",   int'(cfg.edge_thresh), ED);
    tick(0, 0, 0, 1, 0);
    check("t1_no_update", int'(cfg.cfg_update), 0);
    check("t1_pending",   int'(cfg.cfg_pending), 0);

    // 2: brightness auto-repeat, steps at 0,4,6,8
    repeat (10) tick(2, 1, 0, 0, 0);
    check("t2_pending", int'(cfg.cfg_pending), 1);
    check("t2_bright_held", int'(cfg.brightness), BD);
    tick(2, 0, 0, 0, 0);
    tick(2, 0, 0, 1, 0);
    check("t2_bright", int'(cfg.brightness), 12);
    check("t2_update", int'(cfg.cfg_update), 1);
    tick(2, 0, 0, 0, 0);
    check("t2_update_pulse", int'(cfg.cfg_update), 0);

    // 3: blur saturation both ends, colour wrap
    repeat (20) tick(1, 1, 0, 0, 0);
    tick(1, 0, 0, 1, 0);
    check("t3_blur_top", int'(cfg.blur_level), BLUR_MAX);
    repeat (20) tick(1, 0, 1, 0, 0);
    tick(1, 0, 0, 1, 0);
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("t3_blur_floor_pending", int'(cfg.cfg_pending), 0);
    tick(1, 0, 0, 1, 0);
    check("t3_blur_zero", int'(cfg.blur_level), 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 0);
    check("t3_colour_wrap_dn", int'(cfg.colour_sel), 3);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    check("t3_colour_wrap_up", int'(cfg.colour_sel), 0);

    // 4: both buttons together, then release one
    tick(2, 1, 1, 0, 0);
    check("t4_idle", int'(cfg.rpt_state == IDLE), 1);
    repeat (6) tick(2, 1, 0, 0, 0);
    check("t4_no_step", int'(cfg.cfg_pending), 0);
    tick(2, 0, 0, 0, 0);

    // 5: filter switch mid-hold
    repeat (5) tick(2, 1, 0, 0, 0);
    repeat (8) tick(3, 1, 0, 0, 0);
    tick(3, 0, 0, 1, 0);
    check("t5_bright", int'(cfg.brightness), 14);
    check("t5_edge_kept", int'(cfg.edge_thresh), ED);
    tick(3, 1, 0, 0, 0);
    tick(3, 0, 0, 1, 0);
    check("t5_edge_repress", int'(cfg.edge_thresh), ED + 1);

    // 6: step coinciding with frame_start, then reset mid-repeat
    tick(2, 0, 0, 0, 0);
    tick(2, 1, 0, 1, 0);
    check("t6_bright_old", int'(cfg.brightness), 14);
    check("t6_pending", int'(cfg.cfg_pending), 1);
    tick(2, 0, 0, 1, 0);
    check("t6_bright_new", int'(cfg.brightness), 15);
    repeat (7) tick(3, 0, 1, 0, 0);
    check("t6_in_repeat", int'(cfg.rpt_state == REPEAT), 1);
    tick(3, 0, 1, 0, 1);
    check("t6_reset_edge", int'(cfg.edge_thresh), ED);
    check("t6_reset_bright", int'(cfg.brightness), BD);
    check("t6_reset_idle", int'(cfg.rpt_state == IDLE), 1);
    repeat (6) tick(3, 0, 1, 0, 0);
    check("t6_no_step_after_reset", int'(cfg.cfg_pending), 0);

    // random traffic
    ft = 2; inc = 0; dec = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) ft = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0)  inc = ~inc;
      if ($urandom_range(0, 9) == 0)  dec = ~dec;
      fs  = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick(ft, inc, dec, fs, rst);
    end
    tick(ft, 0, 0, 1, 0);
    tick(ft, 0, 0, 0, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
